gpio_bus_master: RTL and testbench
==================================

Name: gpio_bus_master

Overview:
Bus initiator for the 2-bit-address GPIO register window: A=00 gpI1 (read-only), 01 gpI2 (read-only), 10 gpO1 (read/write), 11 gpO2 (read/write). Read data is combinational from A; writes take effect at the clock edge when WE=1.
Accepts single commands (READ, WRITE, POLL) from the control datapath over a valid/ready handshake. Drives A/WE/WD, samples Rd, and returns one response per command over a second valid/ready handshake.
POLL re-reads a register until a masked compare matches or a bounded retry count expires.

Parameters:
POLL_INTERVAL, 4, idle cycles between successive POLL reads (>=1)
POLL_MAX, 1000, max POLL reads before timeout (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  master idle, can accept
cmd_op  in  2  00 READ, 01 WRITE, 10 POLL, 11 reserved
cmd_addr  in  2  GPIO register address
cmd_data  in  32  write data (WRITE) / compare value (POLL)
cmd_mask  in  32  compare mask (POLL only)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  32  read/last-sampled data; 0 for WRITE and errors
rsp_status  out  2  00 OK, 01 TIMEOUT, 10 ERR_RO, 11 ERR_OP
bus_A  out  2  to GPIO A
bus_WE  out  1  to GPIO WE
bus_WD  out  32  to GPIO WD
bus_Rd  in  32  from GPIO Rd

Behaviour:
- All outputs registered. Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_status=00, bus_A=00, bus_WE=0, bus_WD=0; state=IDLE, poll counters=0.
- States: IDLE, WRITE, READ, POLL_WAIT, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready at an edge:
  - Latch op/addr/data/mask.
  - cmd_ready=0 from the next cycle.
  - Go to WRITE, READ (also used for POLL), or RESP (op=11: status ERR_OP, data 0, no bus activity).
- WRITE, addr 10/11: for exactly one cycle bus_A=addr, bus_WE=1, bus_WD=data, so the GPIO register updates at the end of that cycle. Then RESP with status OK, data 0.
- WRITE, addr 00/01: bus_WE stays 0. RESP with ERR_RO, data 0.
- READ: for one cycle bus_A=addr, bus_WE=0; bus_Rd is sampled at the closing edge.
  - READ op: RESP with OK, data=sample.
  - POLL op: increment poll count.
    - If (sample & mask)==(data & mask): RESP with OK, data=sample.
    - Else if count==POLL_MAX: RESP with TIMEOUT, data=last sample.
    - Else go to POLL_WAIT.
  - mask=0 always matches on the first read.
- POLL_WAIT: bus_A held, bus_WE=0, for POLL_INTERVAL cycles, then READ.
- RESP: rsp_valid=1 with data/status stable until rsp_valid&&rsp_ready at an edge. Then rsp_valid=0, go to IDLE, cmd_ready=1 from the next cycle.
- Latency, accept edge E0:
  - WRITE/READ: bus cycle E0–E1, rsp_valid high after E1. With rsp_ready held high, response handshake at E2 and cmd_ready high after E2.
  - ERR_OP: rsp_valid high after E0.
  - POLL matching on read k: rsp_valid high after E0 + k + (k-1)*POLL_INTERVAL cycles.
- bus_WE is asserted only in WRITE with a writable address, never for more than 1 consecutive cycle. bus_A and bus_WD hold their last values outside bus cycles.
- cmd_* is ignored while cmd_ready=0; no queuing. rsp_ready while rsp_valid=0 is ignored.
- Poll counter width is ceil(log2(POLL_MAX+1)), cleared on each accept.
- Reset mid-operation (any state):
  - Immediate return to IDLE with reset values; bus_WE deasserts asynchronously.
  - The in-flight command is dropped and no response is produced.

Test Plan:
- WRITE addr=10 data=0xDEADBEEF, rsp_ready=1 -> bus_WE high exactly 1 cycle with bus_A=10; GPIO gpO1=0xDEADBEEF; rsp OK, data 0, rsp_valid after E1. Follow with READ addr=10 -> rsp_data=0xDEADBEEF.
- READ addr=01, gpI2=0x12345678 -> rsp OK data 0x12345678; bus_WE never high. WRITE addr=00 -> ERR_RO, gpO1/gpO2 unchanged, bus_WE never high.
- POLL addr=00 data=0x00000100 mask=0x00000100, gpI1 bit8 set on 3rd read -> OK, data=gpI1, exactly 3 reads spaced POLL_INTERVAL (4) idle cycles apart. POLL with mask=0 -> OK after 1 read.
- POLL with POLL_MAX=5 and no match -> TIMEOUT after exactly 5 reads, rsp_data=last gpI sample. cmd_op=11 -> ERR_OP, no bus activity.
- Back-pressure: rsp_ready=0 for 10 cycles -> rsp_valid/data/status stable, cmd_ready=0 throughout, further cmd_valid ignored. Release -> single handshake, then cmd_ready=1.
- Assert rst during WRITE cycle and during POLL_WAIT -> bus_WE=0 immediately, all outputs at reset values, no rsp_valid. Next command after deassert runs normally.

Source files
------------

// File: rtl/gpio_bus_master_if.sv
// gpio_bus_master_if: command, response and GPIO register bus signals of the bus master
interface gpio_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic [31:0] cmd_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic [1:0]  bus_A;
  logic        bus_WE;
  logic [31:0] bus_WD;
  logic [31:0] bus_Rd;
  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready, bus_Rd,
    output cmd_ready, rsp_valid, rsp_data, rsp_status, bus_A, bus_WE, bus_WD
  );
  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, rsp_ready, bus_Rd,
    input  cmd_ready, rsp_valid, rsp_data, rsp_status, bus_A, bus_WE, bus_WD
  );
endinterface

// File: rtl/gpio_bus_master.sv
// gpio_bus_master: runs READ/WRITE/POLL commands against the GPIO register window
module gpio_bus_master #(
  parameter int POLL_INTERVAL = 4,
  parameter int POLL_MAX = 1000
) (
  input logic clk,
  input logic rst,
  gpio_bus_master_if.master b
);
  localparam int CW = $clog2(POLL_MAX + 1);
  localparam int IW = $clog2(POLL_INTERVAL + 1);
  localparam logic [CW-1:0] PMAX = CW'(POLL_MAX);
  localparam logic [IW-1:0] ILAST = IW'(POLL_INTERVAL - 1);
  localparam logic [1:0] ST_OK = 2'b00, ST_TIMEOUT = 2'b01, ST_ERR_RO = 2'b10, ST_ERR_OP = 2'b11;
  localparam logic [1:0] OP_READ = 2'b00, OP_WRITE = 2'b01, OP_POLL = 2'b10, OP_RSVD = 2'b11;
  typedef enum logic [2:0] {IDLE, WRITE, READ, POLL_WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d, addr_q, addr_d, rsp_status_q, rsp_status_d, bus_a_q, bus_a_d;
  logic [31:0] data_q, data_d, mask_q, mask_d, rsp_data_q, rsp_data_d, bus_wd_q, bus_wd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] wcnt_q, wcnt_d;
  logic cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, bus_we_q, bus_we_d;
  logic wr, rd, hit, done;
  // next state and registered outputs; bus_WE is a single-cycle pulse
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    addr_d = addr_q;
    data_d = data_q;
    mask_d = mask_q;
    cnt_d = cnt_q;
    wcnt_d = wcnt_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d = rsp_data_q;
    rsp_status_d = rsp_status_q;
    bus_a_d = bus_a_q;
    bus_wd_d = bus_wd_q;
    bus_we_d = 1'b0;
    wr = b.cmd_op == OP_WRITE && b.cmd_addr[1];
    rd = !b.cmd_op[0];
    hit = ((b.bus_Rd ^ data_q) & mask_q) == '0;
    done = 1'b0;
    case (state_q)
      IDLE: if (b.cmd_valid && cmd_ready_q) begin
        op_d = b.cmd_op;
        addr_d = b.cmd_addr;
        data_d = b.cmd_data;
        mask_d = b.cmd_mask;
        cnt_d = '0;
        cmd_ready_d = 1'b0;
        state_d = b.cmd_op == OP_RSVD ? RESP : b.cmd_op == OP_WRITE ? WRITE : READ;
        rsp_valid_d = b.cmd_op == OP_RSVD;
        rsp_data_d = b.cmd_op == OP_RSVD ? '0 : rsp_data_q;
        rsp_status_d = b.cmd_op == OP_RSVD ? ST_ERR_OP : rsp_status_q;
        bus_we_d = wr;
        bus_a_d = (wr || rd) ? b.cmd_addr : bus_a_q;
        bus_wd_d = wr ? b.cmd_data : bus_wd_q;
      end
      WRITE: begin
        state_d = RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d = '0;
        rsp_status_d = addr_q[1] ? ST_OK : ST_ERR_RO;
      end
      READ: begin
        cnt_d = cnt_q + 1'b1;
        done = op_q == OP_READ || hit || cnt_d == PMAX;
        wcnt_d = '0;
        state_d = done ? RESP : POLL_WAIT;
        rsp_valid_d = done;
        rsp_data_d = done ? b.bus_Rd : rsp_data_q;
        rsp_status_d = done ? ((op_q == OP_POLL && !hit) ? ST_TIMEOUT : ST_OK) : rsp_status_q;
      end
      POLL_WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        state_d = wcnt_q == ILAST ? READ : POLL_WAIT;
      end
      RESP: if (b.rsp_ready) begin
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers, cleared immediately by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      mask_q <= '0;
      cnt_q <= '0;
      wcnt_q <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_status_q <= ST_OK;
      bus_a_q <= '0;
      bus_wd_q <= '0;
      bus_we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      addr_q <= addr_d;
      data_q <= data_d;
      mask_q <= mask_d;
      cnt_q <= cnt_d;
      wcnt_q <= wcnt_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      bus_a_q <= bus_a_d;
      bus_wd_q <= bus_wd_d;
      bus_we_q <= bus_we_d;
    end
  end
  assign b.cmd_ready = cmd_ready_q;
  assign b.rsp_valid = rsp_valid_q;
  assign b.rsp_data = rsp_data_q;
  assign b.rsp_status = rsp_status_q;
  assign b.bus_A = bus_a_q;
  assign b.bus_WE = bus_we_q;
  assign b.bus_WD = bus_wd_q;
endmodule

// File: tb/tb_gpio_bus_master.sv
// tb_gpio_bus_master: scoreboard bench for gpio_bus_master with a GPIO register model
module tb_gpio_bus_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  gpio_bus_master_if b();
  gpio_bus_master #(.POLL_INTERVAL(4), .POLL_MAX(5)) dut (.clk(clk), .rst(rst), .b(b));
  logic [31:0] gpi1 = '0, gpi2 = '0, gpo1 = '0, gpo2 = '0;
  assign b.bus_Rd = b.bus_A == 2'd0 ? gpi1 : b.bus_A == 2'd1 ? gpi2 : b.bus_A == 2'd2 ? gpo1 : gpo2;
  // GPIO register window: writable registers update at the edge closing a WE cycle
  always @(posedge clk) if (b.bus_WE) begin
    if (b.bus_A == 2'd2) gpo1 <= b.bus_WD;
    else if (b.bus_A == 2'd3) gpo2 <= b.bus_WD;
  end
  int checks = 0, errors = 0;
  int we_cnt = 0, we_run = 0, we_max = 0;
  logic [1:0] we_a = '0;
  logic [33:0] sb[$];
  logic [33:0] sb_e;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  // bus write tracking and response scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (b.bus_WE) begin
      we_cnt++;
      we_run++;
      we_a = b.bus_A;
      if (we_run > we_max) we_max = we_run;
    end else we_run = 0;
    if (!rst && b.rsp_valid && b.rsp_ready) begin
      check("rsp_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        sb_e = sb.pop_front();
        check("rsp_status", 32'(b.rsp_status), 32'(sb_e[33:32]));
        check("rsp_data", b.rsp_data, sb_e[31:0]);
      end
    end
  end
  task automatic check_reset(input string p);
    check({p, "_cmd_ready"}, 32'(b.cmd_ready), 1);
    check({p, "_rsp_valid"}, 32'(b.rsp_valid), 0);
    check({p, "_rsp_data"}, b.rsp_data, 0);
    check({p, "_rsp_status"}, 32'(b.rsp_status), 0);
    check({p, "_bus_A"}, 32'(b.bus_A), 0);
    check({p, "_bus_WE"}, 32'(b.bus_WE), 0);
    check({p, "_bus_WD"}, b.bus_WD, 0);
  endtask
  task automatic send(input logic [1:0] op, input logic [1:0] addr, input logic [31:0] data, input logic [31:0] mask);
    int n = 0;
    b.cmd_valid = 1'b1;
    b.cmd_op = op;
    b.cmd_addr = addr;
    b.cmd_data = data;
    b.cmd_mask = mask;
    while (!b.cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_in_time", 32'(n < 100), 1);
    @(posedge clk); #1;
    b.cmd_valid = 1'b0;
  endtask
  task automatic run(input logic [1:0] op, input logic [1:0] addr, input logic [31:0] data, input logic [31:0] mask,
                     input logic [1:0] st, input logic [31:0] d, input int lat, input int bp);
    int n = 0;
    sb.push_back({st, d});
    if (bp > 0) b.rsp_ready = 1'b0;
    send(op, addr, data, mask);
    while (!b.rsp_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, lat);
    for (int i = 0; i < bp; i++) begin
      check("bp_valid", 32'(b.rsp_valid), 1);
      check("bp_data", b.rsp_data, d);
      check("bp_status", 32'(b.rsp_status), 32'(st));
      check("bp_cmd_ready", 32'(b.cmd_ready), 0);
      b.cmd_valid = 1'b1;
      b.cmd_op = 2'b01;
      b.cmd_addr = 2'b11;
      b.cmd_data = 32'hBAD0BAD0;
      @(posedge clk); #1;
    end
    b.cmd_valid = 1'b0;
    b.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rsp_valid", 32'(b.rsp_valid), 0);
    check("post_cmd_ready", 32'(b.cmd_ready), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
  initial begin
    int w;
    b.cmd_valid = 1'b0;
    b.cmd_op = '0;
    b.cmd_addr = '0;
    b.cmd_data = '0;
    b.cmd_mask = '0;
    b.rsp_ready = 1'b1;
    gpi2 = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    w = we_cnt;
    run(2'b01, 2'b10, 32'hDEADBEEF, 0, 2'b00, 0, 1, 0);
    check("wr_we_cycles", we_cnt - w, 1);
    check("wr_we_addr", 32'(we_a), 2);
    check("wr_gpo1", gpo1, 32'hDEADBEEF);
    run(2'b00, 2'b10, 0, 0, 2'b00, 32'hDEADBEEF, 1, 0);
    w = we_cnt;
    run(2'b00, 2'b01, 0, 0, 2'b00, 32'h12345678, 1, 0);
    run(2'b01, 2'b00, 32'h11111111, 0, 2'b10, 0, 1, 0);
    check("ro_no_we", we_cnt - w, 0);
    check("ro_gpo1", gpo1, 32'hDEADBEEF);
    check("ro_gpo2", gpo2, 0);
    gpi1 = 32'h000000F0;
    fork begin repeat (8) @(posedge clk); #1; gpi1 = 32'h000001F0; end join_none
    run(2'b10, 2'b00, 32'h100, 32'h100, 2'b00, 32'h1F0, 11, 0);
    run(2'b10, 2'b01, 32'hFFFFFFFF, 0, 2'b00, 32'h12345678, 1, 0);
    gpi2 = 32'h000000A0;
    fork begin repeat (19) @(posedge clk); #1; gpi2 = 32'h000000B0; end join_none
    run(2'b10, 2'b01, 32'h1, 32'h1, 2'b01, 32'hB0, 21, 0);
    gpi2 = 32'h12345678;
    w = we_cnt;
    run(2'b11, 2'b10, 32'h5, 0, 2'b11, 0, 0, 0);
    check("errop_no_we", we_cnt - w, 0);
    check("errop_bus_A_held", 32'(b.bus_A), 1);
    w = we_cnt;
    run(2'b00, 2'b10, 0, 0, 2'b00, 32'hDEADBEEF, 1, 10);
    check("bp_no_we", we_cnt - w, 0);
    check("bp_gpo2", gpo2, 0);
    check("we_max_run", we_max, 1);
    send(2'b01, 2'b11, 32'h55AA55AA, 0);
    check("rstw_we_before", 32'(b.bus_WE), 1);
    #2 rst = 1'b1;
    #1 check_reset("rstw");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rstw_no_rsp", 32'(b.rsp_valid), 0);
    end
    check("rstw_gpo2", gpo2, 0);
    run(2'b00, 2'b10, 0, 0, 2'b00, 32'hDEADBEEF, 1, 0);
    send(2'b10, 2'b00, 32'h1, 32'h1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset("rstp");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rstp_no_rsp", 32'(b.rsp_valid), 0);
    end
    check("rstp_sb_empty", 32'(sb.size()), 0);
    run(2'b01, 2'b11, 32'hCAFEF00D, 0, 2'b00, 0, 1, 0);
    check("final_gpo2", gpo2, 32'hCAFEF00D);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
